// File: rtl/semaforo_monitor_if.sv
// Lamp-side bus between the traffic-light controller and the safety monitor.
// Controller side is the master (drives lamps and clear); the monitor is the slave.
interface semaforo_monitor_if;
  logic [2:0] la;
  logic [2:0] lb;
  logic       clear;
  logic [2:0] safe_la;
  logic [2:0] safe_lb;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] viol_count;

  modport master (
    output la, lb, clear,
    input  safe_la, safe_lb, fault, fault_code, viol_count
  );

  modport slave (
    input  la, lb, clear,
    output safe_la, safe_lb, fault, fault_code, viol_count
  );
endinterface

// File: rtl/semaforo_monitor.sv
// Safety monitor on the controller lamp outputs: one register stage to the pins, forces the fault lamp
// and latches a fault code on any violation. SEMAFORO_FLASH_EN makes the fault lamp a flashing red.
module semaforo_monitor #(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_HOLD   = 64
`ifdef SEMAFORO_FLASH_EN
  ,
  parameter int FLASH_HALF = 4
`endif
) (
  input logic               clk,
  input logic               reset,
  semaforo_monitor_if.slave mon
);

  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int YW = $clog2(MIN_YELLOW + 1);

  function automatic logic is_legal(input logic [2:0] c);
    return (c == LAMP_G) || (c == LAMP_Y) || (c == LAMP_R);
  endfunction

  function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
    return (p == c) || (p == LAMP_G && c == LAMP_Y) ||
           (p == LAMP_Y && c == LAMP_R) || (p == LAMP_R && c == LAMP_G);
  endfunction

  logic [2:0]    prev_la_q, prev_la_d, prev_lb_q, prev_lb_d;
  logic [2:0]    safe_la_q, safe_la_d, safe_lb_q, safe_lb_d;
  logic          fault_q, fault_d;
  logic [2:0]    fault_code_q, fault_code_d;
  logic [7:0]    viol_count_q, viol_count_d;
  logic [YW-1:0] yel_a_q, yel_a_d, yel_b_q, yel_b_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]    fault_lamp;

  logic la_ill, lb_ill, seq_a, seq_b, tim_a, tim_b;
  logic hit_code, hit_conf, hit_seq, hit_tim, hit_stall, viol;
  logic [2:0] code;

`ifdef SEMAFORO_FLASH_EN
  localparam int FW = $clog2(FLASH_HALF + 1);
  logic          flash_phase_q, flash_phase_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;

  always_comb begin
    flash_phase_d = flash_phase_q;
    flash_cnt_d   = flash_cnt_q;
    if (!fault_q) begin
      flash_phase_d = 1'b1;
      flash_cnt_d   = '0;
    end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
      flash_phase_d = ~flash_phase_q;
      flash_cnt_d   = '0;
    end else begin
      flash_cnt_d = flash_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_phase_q <= 1'b1;
      flash_cnt_q   <= '0;
    end else begin
      flash_phase_q <= flash_phase_d;
      flash_cnt_q   <= flash_cnt_d;
    end
  end

  assign fault_lamp = flash_phase_q ? LAMP_R : 3'b000;
`else
  assign fault_lamp = LAMP_R;
`endif

  always_comb begin
    la_ill = !is_legal(mon.la);
    lb_ill = !is_legal(mon.lb);
    // Sequence check is meaningless when either end of the transition is an illegal code.
    seq_a  = !la_ill && is_legal(prev_la_q) && !step_ok(prev_la_q, mon.la);
    seq_b  = !lb_ill && is_legal(prev_lb_q) && !step_ok(prev_lb_q, mon.lb);
    tim_a  = (prev_la_q == LAMP_Y) && (mon.la == LAMP_R) && (yel_a_q < YW'(MIN_YELLOW));
    tim_b  = (prev_lb_q == LAMP_Y) && (mon.lb == LAMP_R) && (yel_b_q < YW'(MIN_YELLOW));

    hit_code  = la_ill | lb_ill;
    hit_conf  = (mon.la != LAMP_R) && (mon.lb != LAMP_R);
    hit_seq   = seq_a | seq_b;
    hit_tim   = tim_a | tim_b;
    hit_stall = (hold_cnt_q == HW'(MAX_HOLD));
    viol      = hit_code | hit_conf | hit_seq | hit_tim | hit_stall;

    code = 3'd0;
    if      (hit_code)  code = 3'd1;
    else if (hit_conf)  code = 3'd2;
    else if (hit_seq)   code = 3'd3;
    else if (hit_tim)   code = 3'd4;
    else if (hit_stall) code = 3'd5;
  end

  always_comb begin
    prev_la_d = mon.la;
    prev_lb_d = mon.lb;

    yel_a_d = '0;
    if (mon.la == LAMP_Y)
      yel_a_d = (yel_a_q == YW'(MIN_YELLOW)) ? yel_a_q : yel_a_q + YW'(1);
    yel_b_d = '0;
    if (mon.lb == LAMP_Y)
      yel_b_d = (yel_b_q == YW'(MIN_YELLOW)) ? yel_b_q : yel_b_q + YW'(1);

    hold_cnt_d = '0;
    if (mon.la == prev_la_q && mon.lb == prev_lb_q)
      hold_cnt_d = (hold_cnt_q == HW'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + HW'(1);

    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    // A violation always beats clear, and a clear request lets the new cause replace the old one.
    if (viol) begin
      fault_d = 1'b1;
      if (!fault_q || mon.clear) fault_code_d = code;
    end else if (mon.clear) begin
      fault_d      = 1'b0;
      fault_code_d = 3'd0;
    end

    viol_count_d = viol_count_q;
    if (viol && viol_count_q != 8'hFF) viol_count_d = viol_count_q + 8'd1;

    safe_la_d = (fault_q || viol) ? fault_lamp : mon.la;
    safe_lb_d = (fault_q || viol) ? fault_lamp : mon.lb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_la_q    <= LAMP_R;
      prev_lb_q    <= LAMP_R;
      safe_la_q    <= LAMP_R;
      safe_lb_q    <= LAMP_R;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
      viol_count_q <= 8'd0;
      yel_a_q      <= '0;
      yel_b_q      <= '0;
      hold_cnt_q   <= '0;
    end else begin
      prev_la_q    <= prev_la_d;
      prev_lb_q    <= prev_lb_d;
      safe_la_q    <= safe_la_d;
      safe_lb_q    <= safe_lb_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      viol_count_q <= viol_count_d;
      yel_a_q      <= yel_a_d;
      yel_b_q      <= yel_b_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign mon.safe_la    = safe_la_q;
  assign mon.safe_lb    = safe_lb_q;
  assign mon.fault      = fault_q;
  assign mon.fault_code = fault_code_q;
  assign mon.viol_count = viol_count_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: each step queues the outputs expected after the next edge,
// and a monitor process compares them one edge later.
module tb_semaforo_monitor;
  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  typedef struct packed {
    logic [2:0] sla;
    logic [2:0] slb;
    logic       f;
    logic [2:0] fc;
    logic [7:0] vc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t  exp_q[$];
  string nm_q[$];

  semaforo_monitor_if bus ();
  semaforo_monitor dut (.clk(clk), .reset(reset), .mon(bus));

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] sla, input logic [2:0] slb, input logic f,
                              input logic [2:0] fc, input logic [7:0] vc);
    exp_t e;
    e.sla = sla; e.slb = slb; e.f = f; e.fc = fc; e.vc = vc;
    return e;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h at %0t", nm, fld, act, want, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] a, input logic [2:0] b,
                      input logic clr, input exp_t e, input string nm);
    reset     = rst;
    bus.la    = a;
    bus.lb    = b;
    bus.clear = clr;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  // Fault lamp expected on the j-th violation edge of the stall run (fault set on j=0).
  function automatic logic [2:0] stall_lamp(input int j);
`ifdef SEMAFORO_FLASH_EN
    if (j == 0) return R;
    return (((j - 1) / 4) % 2 == 0) ? R : 3'b000;
`else
    return (j >= 0) ? R : 3'b000;
`endif
  endfunction

  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk(n, "safe_la",    {5'd0, bus.safe_la},    {5'd0, e.sla});
        chk(n, "safe_lb",    {5'd0, bus.safe_lb},    {5'd0, e.slb});
        chk(n, "fault",      {7'd0, bus.fault},      {7'd0, e.f});
        chk(n, "fault_code", {5'd0, bus.fault_code}, {5'd0, e.fc});
        chk(n, "viol_count", bus.viol_count,         e.vc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    bus.la = R; bus.lb = R; bus.clear = 1'b0;
    #2;
    step(1, R, R, 0, mk(R, R, 0, 0, 0), "reset");
    step(1, R, R, 0, mk(R, R, 0, 0, 0), "reset");

    for (int i = 0; i < 5; i++) step(0, G, R, 0, mk(G, R, 0, 0, 0), "legal_ag");
    for (int i = 0; i < 2; i++) step(0, Y, R, 0, mk(Y, R, 0, 0, 0), "legal_ay");
    step(0, R, R, 0, mk(R, R, 0, 0, 0), "legal_ar");
    step(0, R, G, 0, mk(R, G, 0, 0, 0), "legal_bg");
    for (int i = 0; i < 2; i++) step(0, R, Y, 0, mk(R, Y, 0, 0, 0), "legal_by");
    step(0, R, R, 0, mk(R, R, 0, 0, 0), "legal_br");

    step(0, G, G, 0, mk(R, R, 1, 2, 1), "conflict");
    step(0, R, R, 0, mk(R, R, 1, 2, 2), "conflict_exit_seq");
    step(0, R, R, 0, mk(R, R, 1, 2, 2), "conflict_held");
    step(0, R, R, 1, mk(R, R, 0, 0, 2), "conflict_clear");

    step(0, G, R, 0, mk(G, R, 0, 0, 2), "short_g");
    step(0, Y, R, 0, mk(Y, R, 0, 0, 2), "short_y");
    step(0, R, R, 0, mk(R, R, 1, 4, 3), "short_yellow");
    step(0, R, R, 0, mk(R, R, 1, 4, 3), "short_held");
    step(0, R, R, 1, mk(R, R, 0, 0, 3), "short_clear");

    step(0, 3'b110, G, 0, mk(R, R, 1, 1, 4), "prio_code");
    step(0, R, R, 1, mk(R, R, 1, 3, 5), "clear_vs_seq");
    step(0, R, R, 1, mk(R, R, 0, 0, 5), "prio_clear");
    step(0, 3'b000, R, 0, mk(R, R, 1, 1, 6), "illegal_off");
    step(0, R, R, 0, mk(R, R, 1, 1, 6), "illegal_exit");
    step(0, G, G, 1, mk(R, R, 1, 2, 7), "clear_vs_conflict");
    step(0, R, R, 0, mk(R, R, 1, 2, 8), "conflict2_exit");
    step(0, R, R, 1, mk(R, R, 0, 0, 8), "clear2");
    step(0, R, R, 1, mk(R, R, 0, 0, 8), "clear_noop");

    step(0, G, R, 0, mk(G, R, 0, 0, 8), "stall_start");
    for (int i = 0; i < 64; i++) step(0, G, R, 0, mk(G, R, 0, 0, 8), "stall_hold");
    for (int j = 0; j < 300; j++)
      step(0, G, R, 0, mk(stall_lamp(j), stall_lamp(j), 1, 5,
                          (9 + j > 255) ? 8'd255 : 8'(9 + j)), "stall_viol");

    step(1, G, R, 0, mk(R, R, 0, 0, 0), "reset_mid_fault");
    step(0, G, R, 0, mk(G, R, 0, 0, 0), "after_reset");
    step(0, G, R, 0, mk(G, R, 0, 0, 0), "after_reset_hold");

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
